// File: rtl/i2c_slave_led_if.sv
// I2C pin bundle between a bus controller model and the LED target.
interface i2c_slave_led_if;
    logic scl;
    logic sda_i;
    logic sda_oe;

    modport slave  (input  scl, input  sda_i, output sda_oe);
    modport master (output scl, output sda_i, input  sda_oe);
endinterface

// File: rtl/i2c_slave_led.sv
// I2C target that writes a 7-segment LED register and reads it back.
// Optional hex-to-segment decoding of written bytes: define I2C_SLAVE_HEX_DECODE_EN.
module i2c_slave_led #(
    parameter logic [6:0]  DEV_ADDR   = 7'h3C,
    parameter int unsigned SYNC_DEPTH = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    i2c_slave_led_if.slave   bus,
    output logic [6:0]       led
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK
    } state_t;

    logic [SYNC_DEPTH-1:0] scl_sync;
    logic [SYNC_DEPTH-1:0] sda_sync;
    logic                  scl_d;
    logic                  sda_d;
    logic                  scl_s;
    logic                  sda_s;
    logic                  scl_rise;
    logic                  scl_fall;
    logic                  start_det;
    logic                  stop_det;

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [BYTE_W-1:0]     rx_sh;
    logic [BYTE_W-1:0]     tx_sh;
    logic                  rw;
    logic                  sda_oe;
    logic [6:0]            led_new;

    // Bus idles high, so synchronisers reset to 1 to avoid phantom edges.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_DEPTH-2:0], bus.scl};
            sda_sync <= {sda_sync[SYNC_DEPTH-2:0], bus.sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_DEPTH-1];
    assign sda_s     = sda_sync[SYNC_DEPTH-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & ~sda_s & sda_d;
    assign stop_det  = scl_s & scl_d & sda_s & ~sda_d;

`ifdef I2C_SLAVE_HEX_DECODE_EN
    logic [3:0] wr_nib;
    assign wr_nib = {rx_sh[2:0], sda_s};

    always_comb begin
        led_new = 7'h00;
        case (wr_nib)
            4'h0: led_new = 7'h3F;
            4'h1: led_new = 7'h06;
            4'h2: led_new = 7'h5B;
            4'h3: led_new = 7'h4F;
            4'h4: led_new = 7'h66;
            4'h5: led_new = 7'h6D;
            4'h6: led_new = 7'h7D;
            4'h7: led_new = 7'h07;
            4'h8: led_new = 7'h7F;
            4'h9: led_new = 7'h6F;
            4'hA: led_new = 7'h77;
            4'hB: led_new = 7'h7C;
            4'hC: led_new = 7'h39;
            4'hD: led_new = 7'h5E;
            4'hE: led_new = 7'h79;
            default: led_new = 7'h71;
        endcase
    end
`else
    assign led_new = {rx_sh[5:0], sda_s};
`endif

    // Protocol FSM; tx_sh[7] always holds the next bit to present on a read.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            rx_sh   <= '0;
            tx_sh   <= '0;
            rw      <= 1'b0;
            sda_oe  <= 1'b0;
            led     <= 7'h00;
        end else if (start_det) begin
            state   <= ADDR;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
        end else if (stop_det) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sda_oe <= 1'b0;
                end
                ADDR: begin
                    if (scl_rise) begin
                        rx_sh   <= {rx_sh[6:0], sda_s};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end else if (scl_fall && bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        if (rx_sh[7:1] == DEV_ADDR) begin
                            rw     <= rx_sh[0];
                            sda_oe <= 1'b1;
                            state  <= ADDR_ACK;
                        end else begin
                            state  <= IDLE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw) begin
                            tx_sh   <= {led, 1'b0};
                            sda_oe  <= 1'b1;
                            bit_cnt <= CNT_W'(1);
                            state   <= READ;
                        end else begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        rx_sh   <= {rx_sh[6:0], sda_s};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT - CNT_W'(1)) begin
                            led <= led_new;
                        end
                    end else if (scl_fall && bit_cnt == LAST_BIT) begin
                        sda_oe  <= 1'b1;
                        bit_cnt <= '0;
                        state   <= WRITE_ACK;
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_oe <= 1'b0;
                        state  <= WRITE;
                    end
                end
                READ: begin
                    if (scl_fall) begin
                        if (bit_cnt == LAST_BIT) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= READ_ACK;
                        end else begin
                            sda_oe  <= ~tx_sh[7];
                            tx_sh   <= {tx_sh[6:0], 1'b0};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state <= IDLE;
                        end else begin
                            tx_sh   <= {1'b0, led};
                            bit_cnt <= '0;
                            state   <= READ;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    sda_oe <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe = sda_oe;

endmodule

// File: tb/tb_i2c_slave_led.sv
// Directed bench: bit-banged I2C controller against the LED target.
module tb_i2c_slave_led;

    localparam int unsigned Q = 10;

`ifdef I2C_SLAVE_HEX_DECODE_EN
    localparam logic [6:0] E05 = 7'h6D;
    localparam logic [6:0] E0A = 7'h77;
    localparam logic [6:0] E0F = 7'h71;
    localparam logic [6:0] E7F = 7'h71;
    localparam logic [6:0] E03 = 7'h4F;
`else
    localparam logic [6:0] E05 = 7'h05;
    localparam logic [6:0] E0A = 7'h0A;
    localparam logic [6:0] E0F = 7'h0F;
    localparam logic [6:0] E7F = 7'h7F;
    localparam logic [6:0] E03 = 7'h03;
`endif

    logic        clk = 1'b0;
    logic        n_rst;
    logic        m_low;
    logic [6:0]  led;
    int unsigned oe_cnt = 0;
    int          n_chk = 0;
    int          n_err = 0;

    always #10 clk = ~clk;

    i2c_slave_led_if ifc();

    // Open-drain wired-AND with pull-up.
    assign ifc.sda_i = ~(m_low | ifc.sda_oe);

    i2c_slave_led #(.DEV_ADDR(7'h3C), .SYNC_DEPTH(2)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (ifc),
        .led   (led)
    );

    always @(posedge clk) oe_cnt <= oe_cnt + (ifc.sda_oe ? 1 : 0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_q;
        repeat (Q) @(posedge clk);
        #2;
    endtask

    task automatic i2c_start;
        m_low = 1'b0; wait_q;
        ifc.scl = 1'b1; wait_q;
        m_low = 1'b1; wait_q;
        ifc.scl = 1'b0; wait_q;
    endtask

    task automatic i2c_stop;
        m_low = 1'b1; wait_q;
        ifc.scl = 1'b1; wait_q;
        m_low = 1'b0; wait_q;
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b; wait_q;
        ifc.scl = 1'b1; wait_q; wait_q;
        ifc.scl = 1'b0; wait_q;
    endtask

    task automatic get_bit(output logic b);
        m_low = 1'b0; wait_q;
        ifc.scl = 1'b1; wait_q;
        b = ifc.sda_i; wait_q;
        ifc.scl = 1'b0; wait_q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    // Clock nine bits with no START; an idle target must never pull SDA.
    task automatic idle_probe(input string tag);
        int unsigned snap;
        snap = oe_cnt;
        for (int i = 0; i < 9; i++) send_bit(i[0]);
        chk(tag, oe_cnt - snap, 0);
    endtask

    initial begin
        logic        ack;
        logic [7:0]  rd;
        int unsigned snap;

        n_rst = 1'b0; ifc.scl = 1'b1; m_low = 1'b0;
        repeat (5) @(posedge clk); #2;
        chk("reset_led", led, 7'h00);
        chk("reset_oe", ifc.sda_oe, 1'b0);
        n_rst = 1'b1; wait_q;

        // Single-byte write
        i2c_start;
        write_byte(8'h78, ack); chk("w05_addr_ack", ack, 1'b0);
        write_byte(8'h05, ack); chk("w05_data_ack", ack, 1'b0);
        i2c_stop;
        chk("w05_led", led, E05);

        // Wrong address
        snap = oe_cnt;
        i2c_start;
        write_byte(8'h7A, ack); chk("bad_addr_nack", ack, 1'b1);
        write_byte(8'h55, ack); chk("bad_data_nack", ack, 1'b1);
        i2c_stop;
        chk("bad_oe_never", oe_cnt - snap, 0);
        chk("bad_led_hold", led, E05);

        // Two-byte write
        i2c_start;
        write_byte(8'h78, ack); chk("w2_addr_ack", ack, 1'b0);
        write_byte(8'h0A, ack); chk("w2_d0_ack", ack, 1'b0);
        chk("w2_led_mid", led, E0A);
        write_byte(8'h0F, ack); chk("w2_d1_ack", ack, 1'b0);
        i2c_stop;
        chk("w2_led", led, E0F);

        // Write 0x7F, then read back two bytes
        i2c_start;
        write_byte(8'h78, ack);
        write_byte(8'h7F, ack); chk("w7f_ack", ack, 1'b0);
        i2c_stop;
        chk("w7f_led", led, E7F);
        i2c_start;
        write_byte(8'h79, ack); chk("rd_addr_ack", ack, 1'b0);
        read_byte(1'b0, rd); chk("rd_byte0", rd, {1'b0, E7F});
        read_byte(1'b1, rd); chk("rd_byte1", rd, {1'b0, E7F});
        wait_q;
        chk("rd_nack_oe", ifc.sda_oe, 1'b0);
        idle_probe("rd_nack_idle");
        i2c_stop;

        // Repeated START aborts a partial byte
        i2c_start;
        write_byte(8'h78, ack);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        i2c_start;
        chk("rs_led_hold", led, E7F);
        write_byte(8'h78, ack); chk("rs_addr_ack", ack, 1'b0);
        write_byte(8'h03, ack); chk("rs_data_ack", ack, 1'b0);
        i2c_stop;
        chk("rs_led", led, E03);

        // Reset while the target is driving the data ACK
        i2c_start;
        write_byte(8'h78, ack);
        for (int i = 7; i >= 0; i--) send_bit(i[0] | (i == 3));
        chk("mid_oe_before", ifc.sda_oe, 1'b1);
        n_rst = 1'b0; #1;
        chk("mid_rst_oe", ifc.sda_oe, 1'b0);
        chk("mid_rst_led", led, 7'h00);
        wait_q;
        n_rst = 1'b1; wait_q;
        idle_probe("post_rst_idle");
        i2c_start;
        write_byte(8'h78, ack); chk("post_rst_addr_ack", ack, 1'b0);
        write_byte(8'h03, ack);
        i2c_stop;
        chk("post_rst_led", led, E03);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
